// File: rtl/quad_mac_accumulator.sv
// Four-lane signed multiply-accumulate. Each accepted group of four operand pairs is
// multiplied (S1), reduced through an adder tree (S2) and accumulated (S3). GROUP_LEN
// consecutive groups form one dot product, handed off through a one-entry output buffer.
// A full buffer that is not being drained stalls every stage.
module quad_mac_accumulator #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned GROUP_LEN = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a0,
    input  logic signed [DATA_W-1:0] a1,
    input  logic signed [DATA_W-1:0] a2,
    input  logic signed [DATA_W-1:0] a3,
    input  logic signed [DATA_W-1:0] b0,
    input  logic signed [DATA_W-1:0] b1,
    input  logic signed [DATA_W-1:0] b2,
    input  logic signed [DATA_W-1:0] b3,
    input  logic                     done_n,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [15:0]              result_count,
    output logic                     overflow,
    output logic                     all_done
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = 2 * DATA_W + 2;
    localparam int unsigned GRP_W  = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

    // Group counter
    logic [GRP_W-1:0] grp_q, grp_d;

    // S1: products and tags
    logic                     s1_valid_q, s1_first_q, s1_last_q;
    logic signed [PROD_W-1:0] p0_q, p1_q, p2_q, p3_q;
    logic signed [PROD_W-1:0] p0_d, p1_d, p2_d, p3_d;

    // S2: reduced group sum, already sign-extended to the accumulator width
    logic                    s2_valid_q, s2_first_q, s2_last_q;
    logic signed [ACC_W-1:0] s2_sum_q, s2_sum_d;
    logic signed [SUM_W-1:0] tree_sum;

    // S3: accumulator
    logic                    s3_valid_q, s3_last_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_add;
    logic                    ovf_hit;

    // Output buffer and status
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [15:0]             result_count_q, result_count_d;
    logic                    overflow_q, overflow_d;
    logic                    all_done_q, all_done_d;

    logic stall, accept, tag_first, tag_last, load, drained;

    // Handshake, next-state and datapath arithmetic
    always_comb begin
        stall     = out_valid_q & ~out_ready;
        accept    = in_valid & ~stall;
        tag_first = (grp_q == '0);
        tag_last  = (grp_q == GRP_W'(GROUP_LEN - 1));

        grp_d = grp_q;
        if (accept) begin
            grp_d = tag_last ? '0 : grp_q + 1'b1;
        end

        p0_d = PROD_W'(a0) * PROD_W'(b0);
        p1_d = PROD_W'(a1) * PROD_W'(b1);
        p2_d = PROD_W'(a2) * PROD_W'(b2);
        p3_d = PROD_W'(a3) * PROD_W'(b3);

        // Two extra bits make the four-way sum exact before widening.
        tree_sum = SUM_W'(p0_q) + SUM_W'(p1_q) + SUM_W'(p2_q) + SUM_W'(p3_q);
        s2_sum_d = ACC_W'(tree_sum);

        acc_add = acc_q + s2_sum_q;
        acc_d   = s2_first_q ? s2_sum_q : acc_add;
        // Signed overflow: like-signed operands producing an opposite-signed result.
        ovf_hit = s2_valid_q & ~s2_first_q & ~stall
                & (acc_q[ACC_W-1] == s2_sum_q[ACC_W-1])
                & (acc_add[ACC_W-1] != acc_q[ACC_W-1]);
        overflow_d = overflow_q | ovf_hit;

        load           = s3_valid_q & s3_last_q & ~stall;
        out_valid_d    = load | (out_valid_q & ~out_ready);
        out_data_d     = load ? acc_q : out_data_q;
        result_count_d = result_count_q + 16'(out_valid_q & out_ready);

        drained    = ~s1_valid_q & ~s2_valid_q & ~s3_valid_q & ~out_valid_q & (grp_q == '0);
        all_done_d = all_done_q | (~done_n & drained);
    end

    // Group counter advances once per accepted group
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grp_q <= '0;
        end else begin
            grp_q <= grp_d;
        end
    end

    // S1/S2 pipeline registers; everything holds while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            p0_q       <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            p3_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sum_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            s1_first_q <= tag_first;
            s1_last_q  <= tag_last;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            p3_q       <= p3_d;
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_sum_q   <= s2_sum_d;
        end
    end

    // S3 accumulator: restarts on a first-tagged group, wraps on overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            acc_q      <= '0;
        end else if (!stall) begin
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
            if (s2_valid_q) begin
                acc_q <= acc_d;
            end
        end
    end

    // Output buffer, result counter and sticky status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            result_count_q <= '0;
            overflow_q     <= 1'b0;
            all_done_q     <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            result_count_q <= result_count_d;
            overflow_q     <= overflow_d;
            all_done_q     <= all_done_d;
        end
    end

    assign in_ready     = ~stall;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign result_count = result_count_q;
    assign overflow     = overflow_q;
    assign all_done     = all_done_q;

endmodule

// File: tb/tb_quad_mac_accumulator.sv
// Directed bench for quad_mac_accumulator: a default-parameter instance for the main
// function and a narrow ACC_W=34 / GROUP_LEN=2 instance for overflow and lane mixing.
module tb_quad_mac_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, done_n, out_ready;
    logic signed [15:0] a0, a1, a2, a3, b0, b1, b2, b3;

    logic               in_ready, out_valid, overflow, all_done;
    logic signed [39:0] out_data;
    logic [15:0]        result_count;

    logic               in_ready2, out_valid2, overflow2, all_done2;
    logic signed [33:0] out_data2;
    logic [15:0]        result_count2;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;
    logic signed [63:0] q1[$];
    logic signed [63:0] q2[$];

    quad_mac_accumulator #(
        .DATA_W   (16),
        .ACC_W    (40),
        .GROUP_LEN(32)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a0          (a0),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .b3          (b3),
        .done_n      (done_n),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .result_count(result_count),
        .overflow    (overflow),
        .all_done    (all_done)
    );

    quad_mac_accumulator #(
        .DATA_W   (16),
        .ACC_W    (34),
        .GROUP_LEN(2)
    ) u_dut_narrow (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready2),
        .a0          (a0),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .b3          (b3),
        .done_n      (done_n),
        .out_valid   (out_valid2),
        .out_ready   (out_ready),
        .out_data    (out_data2),
        .result_count(result_count2),
        .overflow    (overflow2),
        .all_done    (all_done2)
    );

    // Capture every handed-off result mid-cycle, ahead of the completing edge
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) q1.push_back(out_data);
        if (reset && out_valid2 && out_ready) q2.push_back(out_data2);
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one group and hold it until accepted; returns #1 after the accepting edge
    task automatic send(input logic signed [15:0] x0, x1, x2, x3, y0, y1, y2, y3);
        int n;
        a0 = x0; a1 = x1; a2 = x2; a3 = x3;
        b0 = y0; b1 = y1; b2 = y2; b3 = y3;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic signed [15:0] x, input logic signed [15:0] y);
        for (int i = 0; i < n; i++) send(x, x, x, x, y, y, y, y);
    endtask

    task automatic wait_results(input bit narrow, input int n);
        int k;
        k = 0;
        while (((narrow ? q2.size() : q1.size()) < n) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(narrow ? "result_wait_narrow" : "result_wait", narrow ? q2.size() : q1.size(), n);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        done_n   = 1'b1;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q1.delete();
        q2.delete();
        stalls = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; done_n = 1'b1; out_ready = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("init_in_ready", in_ready, 1);
        check("init_out_valid", out_valid, 0);

        // Reset mid-stream: one full result buffered and stalled, one group in flight
        send_n(33, 1, 1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_data", out_data, 128);
        check("pre_rst_in_ready", in_ready, 0);
        #2 reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", result_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_all_done", all_done, 0);
        @(negedge clk);
        reset = 1'b1;
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1;

        // Basic product and latency: result valid exactly three edges after the last accept
        out_ready = 1'b1;
        send_n(32, 1, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("lat_t1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_t2", out_valid, 0);
        @(posedge clk); #1;
        check("lat_t3_valid", out_valid, 1);
        check("lat_t3_data", out_data, 128);
        @(posedge clk); #1;
        check("basic_count", result_count, 1);
        check("basic_drained", out_valid, 0);

        // Signed, back-to-back dot products with no input bubble
        do_reset();
        out_ready = 1'b1;
        send_n(32, -3, 5);
        send_n(32, 2, 2);
        in_valid = 1'b0;
        wait_results(1'b0, 2);
        check("b2b_first", q1[0], -1920);
        check("b2b_second", q1[1], 512);
        check("b2b_no_bubble", stalls, 0);
        check("b2b_count", result_count, 2);

        // Backpressure: first result held while inputs keep arriving
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                send_n(32, 1, 1);
                send_n(32, 1, 2);
                in_valid = 1'b0;
            end
            begin : bp_watch
                int k;
                k = 0;
                while (!out_valid && k < 200) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("bp_valid", out_valid, 1);
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_hold", out_data, 128);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_results(1'b0, 2);
        check("bp_first", q1[0], 128);
        check("bp_second", q1[1], 256);
        check("bp_stalled", stalls > 0, 1);

        // End of stream after a complete final group
        do_reset();
        out_ready = 1'b0;
        send_n(32, 1, 1);
        in_valid = 1'b0;
        done_n   = 1'b0;
        begin : eos_wait
            int k;
            k = 0;
            while (!out_valid && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("eos_buffered", out_valid, 1);
        check("eos_pre", all_done, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("eos_emptied", out_valid, 0);
        check("eos_handshake_edge", all_done, 0);
        @(posedge clk); #1;
        check("eos_done", all_done, 1);
        done_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("eos_sticky", all_done, 1);

        // End of stream mid-dot-product never completes
        do_reset();
        out_ready = 1'b1;
        send_n(5, 1, 1);
        in_valid = 1'b0;
        done_n   = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("partial_all_done", all_done, 0);
        check("partial_no_result", out_valid, 0);

        // Overflow and per-lane mixing on the narrow instance
        do_reset();
        out_ready = 1'b1;
        send_n(2, -16'sd32768, -16'sd32768);
        send_n(2, 1, 1);
        send(1, 2, 3, 4, 5, -6, 7, -8);
        send(-7, 11, 13, -17, 3, 2, -5, 4);
        in_valid = 1'b0;
        wait_results(1'b1, 3);
        check("ovf_wrapped", q2[0], -64'sd8589934592);
        check("ovf_clean", q2[1], 8);
        check("mix_lanes", q2[2], -150);
        check("ovf_sticky", overflow2, 1);
        check("ovf_count", result_count2, 3);
        check("ovf_wide_clear", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
